// File: rtl/oneshot_scheduler_if.sv
// Bundle of the scheduler's per-requester inputs and its registered outputs.
// The testbench drives the master side; the scheduler uses the slave side.
interface oneshot_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic                  ce;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic                  q;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       pending;
  logic                  busy;

  modport master (
    output ce, req, len,
    input  q, grant, done, pending, busy
  );

  modport slave (
    input  ce, req, len,
    output q, grant, done, pending, busy
  );
endinterface

// File: rtl/oneshot_scheduler.sv
// One-shot pulse scheduler: rising edges on req queue requests, which are served
// round-robin, one at a time, as a single pulse of len_i ticks on the shared q.
// Every register advances only on clk edges where ce=1.
module oneshot_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  oneshot_scheduler_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE       = NREQ'(1);
  localparam logic [IW-1:0]   LAST_INIT = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   req_prev_q;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              q_q, q_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   rise;
  logic [IW-1:0]     winner;
  logic              found;
  logic [WIDTH-1:0]  win_len;

  assign rise = bus.req & ~req_prev_q;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && pending_q[(int'(last_q) + k) % NREQ]) begin
        winner = IW'((int'(last_q) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  // Pick the selected requester's length out of the packed len bus.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) win_len = bus.len[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d   = state_q;
    pending_d = pending_q | rise;
    grant_d   = grant_q;
    done_d    = '0;
    q_d       = q_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          cur_d   = winner;
          grant_d = ONE << winner;
          if (win_len != '0) begin
            cnt_d   = win_len - WIDTH'(1);
            q_d     = 1'b1;
            state_d = RUN;
          end else begin
            // Zero-length request skips RUN, so the counter never wraps.
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          q_d     = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      DONE: begin
        done_d    = ONE << cur_q;
        // A fresh edge in the same tick re-queues the requester being cleared.
        pending_d = (pending_q & ~(ONE << cur_q)) | rise;
        last_d    = cur_q;
        grant_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset beats ce, and ce=0 edges hold everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      // NOTE: only control registers exist here, so all of them are reset explicitly.
      state_q    <= IDLE;
      req_prev_q <= bus.req;
      pending_q  <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      q_q        <= 1'b0;
      cnt_q      <= '0;
      cur_q      <= '0;
      last_q     <= LAST_INIT;
    end else if (bus.ce) begin
      state_q    <= state_d;
      req_prev_q <= bus.req;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.pending = pending_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_oneshot_scheduler.sv
// Testbench for oneshot_scheduler: a timeline model of the job schedule predicts
// every cycle's outputs and every completion; a monitor compares DUT outputs.
`timescale 1ns/1ps
module tb_oneshot_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    bit              ticked;
    logic            q;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] pending;
    logic            busy;
  } snap_t;

  typedef struct {
    logic [NREQ-1:0] vec;
    int              len;
  } ev_t;

  logic clk;
  logic reset;

  oneshot_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  oneshot_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  snap_t snap_q[$];
  ev_t   ev_q[$];

  logic [NREQ-1:0]       cur_req;
  logic [NREQ*WIDTH-1:0] cur_len;

  // Reference model: job timeline in tick numbers.
  logic [NREQ-1:0] m_pend;
  logic [NREQ-1:0] m_prev;
  logic [NREQ-1:0] m_done;
  bit              m_active;
  int              m_id, m_len, m_start, m_last, m_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void set_len(input int i, input int v);
    cur_len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endfunction

  // Drive one clock's inputs, advance the model across that edge, queue the expectation.
  task automatic step(input bit rst, input bit ce_i, input logic [NREQ-1:0] req_i,
                      input logic [NREQ*WIDTH-1:0] len_i);
    logic [NREQ-1:0] rise;
    snap_t s;
    ev_t   e;
    int    w;
    @(negedge clk);
    reset   = rst;
    bus.ce  = ce_i;
    bus.req = req_i;
    bus.len = len_i;
    if (rst) begin
      m_pend = '0; m_done = '0; m_active = 0; m_last = NREQ - 1; m_prev = req_i;
    end else if (ce_i) begin
      m_n++;
      rise   = req_i & ~m_prev;
      m_prev = req_i;
      m_done = '0;
      if (m_active && m_n == m_start + m_len + 1) begin
        m_done         = NREQ'(1) << m_id;
        m_pend[m_id]   = 1'b0;
        m_last         = m_id;
        m_active       = 0;
        e.vec          = m_done;
        e.len          = m_len;
        ev_q.push_back(e);
      end else if (!m_active && m_pend != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && m_pend[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        end
        m_active = 1;
        m_id     = w;
        m_start  = m_n;
        m_len    = int'(len_i[w*WIDTH +: WIDTH]);
      end
      m_pend = m_pend | rise;
    end
    s.ticked  = ce_i && !rst;
    s.q       = m_active && (m_n - m_start) < m_len;
    s.grant   = m_active ? (NREQ'(1) << m_id) : '0;
    s.busy    = m_active;
    s.done    = m_done;
    s.pending = m_pend;
    snap_q.push_back(s);
  endtask

  task automatic tick();
    step(1'b0, 1'b1, cur_req, cur_len);
  endtask

  // Monitor: compare every cycle's outputs and every completion event.
  initial begin : monitor
    snap_t s;
    ev_t   e;
    int    wcnt = 0;
    logic [NREQ-1:0] prev_grant = '0;
    forever begin
      @(posedge clk);
      #1;
      if (snap_q.size() != 0) begin
        s = snap_q.pop_front();
        check("q",       32'(bus.q),       32'(s.q));
        check("grant",   32'(bus.grant),   32'(s.grant));
        check("done",    32'(bus.done),    32'(s.done));
        check("pending", 32'(bus.pending), 32'(s.pending));
        check("busy",    32'(bus.busy),    32'(s.busy));
        if (s.ticked) begin
          if (bus.grant != '0 && prev_grant == '0) wcnt = 0;
          if (bus.q) wcnt++;
          prev_grant = bus.grant;
          if (bus.done != '0) begin
            if (ev_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL done_event: got %0h expected none at %0t", bus.done, $time);
            end else begin
              e = ev_q.pop_front();
              check("done_id",  32'(bus.done), 32'(e.vec));
              check("q_width",  32'(wcnt),     32'(e.len));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit r;
    reset = 1'b1; bus.ce = 1'b0; bus.req = '0; bus.len = '0;
    cur_req = '0; cur_len = '0;
    m_pend = '0; m_prev = '0; m_done = '0; m_active = 0;
    m_id = 0; m_len = 0; m_start = 0; m_last = NREQ - 1; m_n = 0;

    repeat (3) step(1'b1, 1'b1, cur_req, cur_len);

    // Single pulse, len 3.
    set_len(0, 3);
    cur_req[0] = 1'b1; tick(); cur_req[0] = 1'b0;
    repeat (8) tick();

    // All four at once, lens 1..4: round-robin order 0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_len(i, i + 1);
    cur_req = '1; tick(); cur_req = '0;
    repeat (24) tick();

    // Zero-length request.
    set_len(2, 0);
    cur_req[2] = 1'b1; tick(); cur_req[2] = 1'b0;
    repeat (5) tick();

    // ce toggling with len 4.
    set_len(1, 4);
    cur_req[1] = 1'b1; tick(); cur_req[1] = 1'b0;
    for (int c = 0; c < 24; c++) step(1'b0, (c % 2) == 0, cur_req, cur_len);

    // len change during RUN must not affect the pulse.
    set_len(0, 5);
    cur_req[0] = 1'b1; tick(); cur_req[0] = 1'b0;
    tick(); tick();
    set_len(0, 1);
    repeat (10) tick();

    // Edge on requester 1 in its own DONE tick, with requester 2 queued.
    set_len(1, 2); set_len(2, 1);
    cur_req[1] = 1'b1; tick(); cur_req[1] = 1'b0;
    cur_req[2] = 1'b1; tick(); cur_req[2] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cur_req[1] = m_active && m_id == 1 && (m_n + 1 == m_start + m_len + 1);
      tick();
    end
    cur_req[1] = 1'b0;
    repeat (10) tick();

    // Maximum pulse length.
    set_len(3, 255);
    cur_req[3] = 1'b1; tick(); cur_req[3] = 1'b0;
    repeat (262) tick();

    // Reset mid-RUN, with req[0] rising during reset and held after it.
    set_len(3, 10);
    cur_req[3] = 1'b1; tick(); cur_req[3] = 1'b0;
    repeat (5) tick();
    cur_req[0] = 1'b1;
    step(1'b1, 1'b1, cur_req, cur_len);
    step(1'b1, 1'b0, cur_req, cur_len);
    repeat (8) tick();
    cur_req = '0;
    repeat (3) tick();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(0, 399) == 0);
      cur_req = cur_req ^ NREQ'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) set_len($urandom_range(0, NREQ - 1), $urandom_range(0, 5));
      step(r, $urandom_range(0, 3) != 0, cur_req, cur_len);
    end

    // Drain all outstanding requests within a bounded number of ticks.
    cur_req = '0;
    for (int c = 0; c < 600 && (m_active || m_pend != '0); c++) tick();
    if (m_active || m_pend != '0) begin
      checks++;
      errors++;
      $display("FAIL drain: got busy expected idle within budget");
    end
    repeat (4) tick();
    repeat (3) @(posedge clk);
    #2;
    check("events_left", 32'(ev_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
